inst_fetch_queue: RTL

Instruction fetch queue between `pc_reg` and the `if_id` pipeline register. Takes the fetch address from `pc_reg` and issues requests to instruction memory over a valid/ready handshake. Tracks in-order responses that may arrive several cycles later and buffers up to `DEPTH` fetched instructions with their PCs. Presents them to decode with a valid/ready handshake, back-pressures `pc_reg` through `pc_stall`, and discards buffered and in-flight fetches on `flush`.

---
 rtl/inst_fetch_queue_if.sv | 35 +++
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between pc_reg, instruction memory, the fetch queue and decode.
//   pc / ce / pc_stall                 : fetch address, enable and hold-back to pc_reg
//   flush                              : redirect, kills queued and in-flight fetches
//   rom_req_valid/ready, rom_addr      : request channel to instruction memory
//   rom_resp_valid, rom_resp_inst      : in-order response channel (no back-pressure)
//   if_valid, if_pc, if_inst, id_ready : head-of-queue handshake to decode
// Modport master is the fetch queue; slave is the surrounding pipeline/memory.
interface inst_fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              pc_stall;
  logic              flush;
  logic              rom_req_valid;
  logic              rom_req_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_resp_valid;
  logic [INST_W-1:0] rom_resp_inst;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              id_ready;

  modport master (
    input  pc, ce, flush, rom_req_ready, rom_resp_valid, rom_resp_inst, id_ready,
    output pc_stall, rom_req_valid, rom_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output pc, ce, flush, rom_req_ready, rom_resp_valid, rom_resp_inst, id_ready,
    input  pc_stall, rom_req_valid, rom_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between pc_reg and the if_id register.
// Issues fetch requests for pc, tracks in-order memory responses, buffers up to DEPTH
// instructions with their PCs and hands them to decode in order. A flush empties the
// queue and remembers how many in-flight responses must still be thrown away.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : inst_fetch_queue_if.master (pc_reg, memory and decode handshakes)
module inst_fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t Full = cnt_t'(DEPTH);

  logic [ADDR_W-1:0] pc_q     [DEPTH];
  logic [INST_W-1:0] inst_q   [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  ptr_t              head_q, alloc_q, fill_q;
  cnt_t              count_q;
  // Allocated entries still waiting for their response.
  cnt_t              pend_q;
  // Responses still owed to requests killed by a flush.
  cnt_t              drop_q;

  logic req_valid, accept, head_valid, deq, fill, drop_resp;
  cnt_t count_d, pend_d, owed, flush_drop;

  always_comb begin
    // Gated by rst so no request is presented while held in reset.
    req_valid = rst & bus.ce & ~bus.flush & (drop_q == '0) & (count_q < Full);
    accept    = req_valid & bus.rom_req_ready;

    bus.rom_req_valid = req_valid;
    bus.rom_addr      = bus.pc;
    bus.pc_stall      = bus.ce & ~accept;

    head_valid   = filled_q[head_q];
    bus.if_valid = head_valid;
    bus.if_pc    = head_valid ? pc_q[head_q] : '0;
    bus.if_inst  = head_valid ? inst_q[head_q] : '0;

    deq       = head_valid & bus.id_ready & ~bus.flush;
    drop_resp = bus.rom_resp_valid & (drop_q != '0);
    // A response with nothing pending is a protocol error and is ignored.
    fill      = bus.rom_resp_valid & ~bus.flush & (drop_q == '0) & (pend_q != '0);

    count_d = count_q + cnt_t'(accept) - cnt_t'(deq);
    pend_d  = pend_q + cnt_t'(accept) - cnt_t'(fill);

    // On flush every unfilled allocation becomes a response to drop; a response in the
    // flush cycle itself is already one of those.
    owed       = pend_q + drop_q;
    flush_drop = (bus.rom_resp_valid && owed != '0) ? owed - cnt_t'(1) : owed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
    end else if (bus.flush) begin
      filled_q <= '0;
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= flush_drop;
    end else begin
      // Alloc, fill and head always address distinct entries when active together.
      if (accept) begin
        pc_q[alloc_q]     <= bus.pc;
        inst_q[alloc_q]   <= '0;
        filled_q[alloc_q] <= 1'b0;
        alloc_q           <= alloc_q + ptr_t'(1);
      end
      if (fill) begin
        inst_q[fill_q]   <= bus.rom_resp_inst;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + ptr_t'(1);
      end
      if (deq) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + ptr_t'(1);
      end
      if (drop_resp) begin
        drop_q <= drop_q - cnt_t'(1);
      end
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

endmodule
